pc_gen: RTL and testbench

PC_GEN -- requirements
Module: pc_gen

---
 rtl/pc_gen.sv | 139 +++++++++++++
 tb/tb_pc_gen.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/pc_gen.sv
// Fetch PC generator: IDLE/RUN control, prioritized redirects, fetch-group masking.
// Define PC_GEN_RAS_EN to build the return address stack for call/return prediction.
module pc_gen #(
    parameter int                    PC_WIDTH     = 32,
    parameter int                    FETCH_WIDTH  = 2,
    parameter logic [PC_WIDTH-1:0]   RESET_VECTOR = '0,
    parameter int                    RAS_DEPTH    = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cpu_en,
    input  logic                   pc_stall,
    input  logic                   fetch_ready,
    output logic                   fetch_valid,
    output logic [PC_WIDTH-1:0]    fetch_pc,
    output logic [FETCH_WIDTH-1:0] fetch_mask,
    input  logic                   ctrl_valid,
    input  logic [PC_WIDTH-1:0]    ctrl_pc,
    input  logic                   br_taken,
    input  logic [PC_WIDTH-1:0]    br_addr,
    input  logic                   jp_taken,
    input  logic [PC_WIDTH-1:0]    jp_addr,
    input  logic                   call_en,
    input  logic [PC_WIDTH-1:0]    call_ret_addr,
    input  logic                   ret_en,
    output logic                   ras_empty
);

    localparam int                  OFF_W      = $clog2(FETCH_WIDTH) + 2;
    localparam logic [PC_WIDTH-1:0] STEP       = PC_WIDTH'(FETCH_WIDTH * 4);
    localparam logic [PC_WIDTH-1:0] GROUP_MASK = ~PC_WIDTH'(FETCH_WIDTH * 4 - 1);
    localparam logic [PC_WIDTH-1:0] WORD_MASK  = ~PC_WIDTH'(3);

    typedef enum logic {IDLE, RUN} state_t;

    state_t              state, state_nxt;
    logic [PC_WIDTH-1:0] pc, pc_nxt;
    logic                active;
    logic                flush;
    logic                ras_hit;
    logic [PC_WIDTH-1:0] ras_top;

    assign active      = (state == RUN) && cpu_en;
    // A trap or backend branch flushes decode, so its call/ret indications are stale.
    assign flush       = ctrl_valid || br_taken;
    assign fetch_valid = (state == RUN);
    assign fetch_pc    = pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            pc    <= RESET_VECTOR & WORD_MASK;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        case (state)
            IDLE: begin
                if (cpu_en) state_nxt = RUN;
            end
            RUN: begin
                if (!cpu_en)
                    state_nxt = IDLE;
                else if (ctrl_valid)
                    pc_nxt = ctrl_pc & WORD_MASK;
                else if (br_taken)
                    pc_nxt = br_addr & WORD_MASK;
                else if (ras_hit)
                    pc_nxt = ras_top & WORD_MASK;
                else if (jp_taken)
                    pc_nxt = jp_addr & WORD_MASK;
                else if (fetch_ready && !pc_stall)
                    pc_nxt = (pc & GROUP_MASK) + STEP;
            end
            default: state_nxt = IDLE;
        endcase
    end

    generate
        if (FETCH_WIDTH == 1) begin : g_mask_single
            assign fetch_mask = 1'b1;
        end else begin : g_mask_group
            localparam int SLOT_W = OFF_W - 2;
            logic [SLOT_W-1:0] slot;
            assign slot = pc[OFF_W-1:2];
            always_comb begin
                fetch_mask = '0;
                for (int i = 0; i < FETCH_WIDTH; i++)
                    fetch_mask[i] = (SLOT_W'(i) >= slot);
            end
        end
    endgenerate

`ifdef PC_GEN_RAS_EN
    localparam int PTR_W = $clog2(RAS_DEPTH);

    logic [PC_WIDTH-1:0] ras_mem [RAS_DEPTH];
    logic [PTR_W-1:0]    top_ptr;
    logic [PTR_W:0]      count;
    logic                push;

    assign ras_empty = (count == '0);
    assign ras_top   = ras_mem[top_ptr];
    assign ras_hit   = active && !flush && ret_en && !ras_empty;
    assign push      = active && !flush && call_en;

    // Circular stack: a push when full simply overwrites the oldest slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            top_ptr <= '0;
            count   <= '0;
            for (int i = 0; i < RAS_DEPTH; i++)
                ras_mem[i] <= '0;
        end else if (push && ras_hit) begin
            ras_mem[top_ptr] <= call_ret_addr;
        end else if (push) begin
            ras_mem[top_ptr + PTR_W'(1)] <= call_ret_addr;
            top_ptr <= top_ptr + PTR_W'(1);
            if (count != (PTR_W + 1)'(RAS_DEPTH))
                count <= count + 1'b1;
        end else if (ras_hit) begin
            top_ptr <= top_ptr - PTR_W'(1);
            count   <= count - 1'b1;
        end
    end
`else
    logic unused_ras;
    assign unused_ras = ^{call_en, ret_en, call_ret_addr, flush};
    assign ras_empty  = 1'b1;
    assign ras_hit    = 1'b0;
    assign ras_top    = '0;
`endif

endmodule

// File: tb/tb_pc_gen.sv
// Directed self-checking bench for pc_gen (FETCH_WIDTH=2, RESET_VECTOR=0x1000, RAS_DEPTH=2).
module tb_pc_gen;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cpu_en, pc_stall, fetch_ready;
    logic        fetch_valid;
    logic [31:0] fetch_pc;
    logic [1:0]  fetch_mask;
    logic        ctrl_valid, br_taken, jp_taken, call_en, ret_en;
    logic [31:0] ctrl_pc, br_addr, jp_addr, call_ret_addr;
    logic        ras_empty;

    int checks = 0;
    int errors = 0;

    pc_gen #(
        .PC_WIDTH    (32),
        .FETCH_WIDTH (2),
        .RESET_VECTOR(32'h1000),
        .RAS_DEPTH   (2)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cpu_en       (cpu_en),
        .pc_stall     (pc_stall),
        .fetch_ready  (fetch_ready),
        .fetch_valid  (fetch_valid),
        .fetch_pc     (fetch_pc),
        .fetch_mask   (fetch_mask),
        .ctrl_valid   (ctrl_valid),
        .ctrl_pc      (ctrl_pc),
        .br_taken     (br_taken),
        .br_addr      (br_addr),
        .jp_taken     (jp_taken),
        .jp_addr      (jp_addr),
        .call_en      (call_en),
        .call_ret_addr(call_ret_addr),
        .ret_en       (ret_en),
        .ras_empty    (ras_empty)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; cpu_en = 1'b0; pc_stall = 1'b0; fetch_ready = 1'b0;
        ctrl_valid = 1'b0; br_taken = 1'b0; jp_taken = 1'b0;
        call_en = 1'b0; ret_en = 1'b0;
        ctrl_pc = '0; br_addr = '0; jp_addr = '0; call_ret_addr = '0;
        tick(); tick();
        checks++; if (fetch_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid got %b want 0", fetch_valid); end
        checks++; if (fetch_pc !== 32'h1000) begin errors++; $display("[TB] FAIL reset_pc got %h want 00001000", fetch_pc); end
        checks++; if (ras_empty !== 1'b1) begin errors++; $display("[TB] FAIL reset_ras_empty got %b want 1", ras_empty); end
        rst_n = 1'b1;
        tick();
        checks++; if (fetch_valid !== 1'b0) begin errors++; $display("[TB] FAIL idle_valid got %b want 0", fetch_valid); end
    endtask

    task automatic test_sequential();
        cpu_en = 1'b1; fetch_ready = 1'b1;
        tick();
        checks++; if (fetch_valid !== 1'b1) begin errors++; $display("[TB] FAIL run_valid got %b want 1", fetch_valid); end
        checks++; if (fetch_pc !== 32'h1000) begin errors++; $display("[TB] FAIL seq0_pc got %h want 00001000", fetch_pc); end
        checks++; if (fetch_mask !== 2'b11) begin errors++; $display("[TB] FAIL seq0_mask got %b want 11", fetch_mask); end
        tick();
        checks++; if (fetch_pc !== 32'h1008) begin errors++; $display("[TB] FAIL seq1_pc got %h want 00001008", fetch_pc); end
        tick();
        checks++; if (fetch_pc !== 32'h1010) begin errors++; $display("[TB] FAIL seq2_pc got %h want 00001010", fetch_pc); end
        checks++; if (fetch_mask !== 2'b11) begin errors++; $display("[TB] FAIL seq2_mask got %b want 11", fetch_mask); end
    endtask

    task automatic test_ready_stall();
        jp_taken = 1'b1; jp_addr = 32'h1008;
        tick();
        jp_taken = 1'b0; fetch_ready = 1'b0;
        checks++; if (fetch_pc !== 32'h1008) begin errors++; $display("[TB] FAIL hold_start_pc got %h want 00001008", fetch_pc); end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (fetch_pc !== 32'h1008) begin errors++; $display("[TB] FAIL hold_pc[%0d] got %h want 00001008", i, fetch_pc); end
        end
        fetch_ready = 1'b1;
        tick();
        checks++; if (fetch_pc !== 32'h1010) begin errors++; $display("[TB] FAIL ready_resume_pc got %h want 00001010", fetch_pc); end
        pc_stall = 1'b1;
        tick(); tick();
        checks++; if (fetch_pc !== 32'h1010) begin errors++; $display("[TB] FAIL stall_pc got %h want 00001010", fetch_pc); end
        pc_stall = 1'b0;
        tick();
        checks++; if (fetch_pc !== 32'h1018) begin errors++; $display("[TB] FAIL stall_resume_pc got %h want 00001018", fetch_pc); end
    endtask

    task automatic test_jump();
        jp_taken = 1'b1; jp_addr = 32'h2004;
        tick();
        jp_taken = 1'b0;
        checks++; if (fetch_pc !== 32'h2004) begin errors++; $display("[TB] FAIL jump_pc got %h want 00002004", fetch_pc); end
        checks++; if (fetch_mask !== 2'b10) begin errors++; $display("[TB] FAIL jump_mask got %b want 10", fetch_mask); end
        tick();
        checks++; if (fetch_pc !== 32'h2008) begin errors++; $display("[TB] FAIL jump_next_pc got %h want 00002008", fetch_pc); end
        checks++; if (fetch_mask !== 2'b11) begin errors++; $display("[TB] FAIL jump_next_mask got %b want 11", fetch_mask); end
        jp_taken = 1'b1; jp_addr = 32'h3007;
        tick();
        jp_taken = 1'b0;
        checks++; if (fetch_pc !== 32'h3004) begin errors++; $display("[TB] FAIL jump_align_pc got %h want 00003004", fetch_pc); end
    endtask

    task automatic test_priority();
        fetch_ready = 1'b0; pc_stall = 1'b1;
        ctrl_valid = 1'b1; ctrl_pc = 32'h80;
        br_taken = 1'b1; br_addr = 32'h300;
        jp_taken = 1'b1; jp_addr = 32'h400;
        tick();
        ctrl_valid = 1'b0;
        checks++; if (fetch_pc !== 32'h80) begin errors++; $display("[TB] FAIL prio_ctrl_pc got %h want 00000080", fetch_pc); end
        tick();
        br_taken = 1'b0;
        checks++; if (fetch_pc !== 32'h300) begin errors++; $display("[TB] FAIL prio_br_pc got %h want 00000300", fetch_pc); end
        tick();
        jp_taken = 1'b0;
        checks++; if (fetch_pc !== 32'h400) begin errors++; $display("[TB] FAIL prio_jp_pc got %h want 00000400", fetch_pc); end
        fetch_ready = 1'b1; pc_stall = 1'b0;
    endtask

    task automatic test_wrap();
        jp_taken = 1'b1; jp_addr = 32'hFFFF_FFF8;
        tick();
        jp_taken = 1'b0;
        checks++; if (fetch_pc !== 32'hFFFF_FFF8) begin errors++; $display("[TB] FAIL wrap_start_pc got %h want fffffff8", fetch_pc); end
        checks++; if (fetch_mask !== 2'b11) begin errors++; $display("[TB] FAIL wrap_mask got %b want 11", fetch_mask); end
        tick();
        checks++; if (fetch_pc !== 32'h0) begin errors++; $display("[TB] FAIL wrap_pc got %h want 00000000", fetch_pc); end
    endtask

    task automatic test_ras();
        fetch_ready = 1'b0;
`ifdef PC_GEN_RAS_EN
        call_en = 1'b1; call_ret_addr = 32'hA0; tick();
        call_ret_addr = 32'hB0; tick();
        call_ret_addr = 32'hC0; tick();
        call_en = 1'b0;
        checks++; if (ras_empty !== 1'b0) begin errors++; $display("[TB] FAIL ras_full_empty got %b want 0", ras_empty); end
        ret_en = 1'b1;
        tick();
        checks++; if (fetch_pc !== 32'hC0) begin errors++; $display("[TB] FAIL ras_pop1_pc got %h want 000000c0", fetch_pc); end
        tick();
        checks++; if (fetch_pc !== 32'hB0) begin errors++; $display("[TB] FAIL ras_pop2_pc got %h want 000000b0", fetch_pc); end
        checks++; if (ras_empty !== 1'b1) begin errors++; $display("[TB] FAIL ras_pop2_empty got %b want 1", ras_empty); end
        tick();
        ret_en = 1'b0;
        checks++; if (fetch_pc !== 32'hB0) begin errors++; $display("[TB] FAIL ras_pop3_pc got %h want 000000b0", fetch_pc); end
        checks++; if (ras_empty !== 1'b1) begin errors++; $display("[TB] FAIL ras_pop3_empty got %b want 1", ras_empty); end
        call_en = 1'b1; call_ret_addr = 32'h100; tick();
        call_ret_addr = 32'h200; ret_en = 1'b1; tick();
        call_en = 1'b0;
        checks++; if (fetch_pc !== 32'h100) begin errors++; $display("[TB] FAIL ras_swap_pc got %h want 00000100", fetch_pc); end
        checks++; if (ras_empty !== 1'b0) begin errors++; $display("[TB] FAIL ras_swap_empty got %b want 0", ras_empty); end
        tick();
        ret_en = 1'b0;
        checks++; if (fetch_pc !== 32'h200) begin errors++; $display("[TB] FAIL ras_swap_pop_pc got %h want 00000200", fetch_pc); end
        checks++; if (ras_empty !== 1'b1) begin errors++; $display("[TB] FAIL ras_swap_pop_empty got %b want 1", ras_empty); end
        ctrl_valid = 1'b1; ctrl_pc = 32'h40; call_en = 1'b1; call_ret_addr = 32'h500;
        tick();
        ctrl_valid = 1'b0; call_en = 1'b0;
        checks++; if (fetch_pc !== 32'h40) begin errors++; $display("[TB] FAIL ras_flush_pc got %h want 00000040", fetch_pc); end
        checks++; if (ras_empty !== 1'b1) begin errors++; $display("[TB] FAIL ras_flush_empty got %b want 1", ras_empty); end
`else
        call_en = 1'b1; call_ret_addr = 32'hA0; tick();
        call_en = 1'b0; ret_en = 1'b1; tick();
        ret_en = 1'b0;
        checks++; if (fetch_pc !== 32'h0) begin errors++; $display("[TB] FAIL noras_ret_pc got %h want 00000000", fetch_pc); end
        checks++; if (ras_empty !== 1'b1) begin errors++; $display("[TB] FAIL noras_empty got %b want 1", ras_empty); end
`endif
        fetch_ready = 1'b1;
    endtask

    task automatic test_disable();
        jp_taken = 1'b1; jp_addr = 32'h600;
        tick();
        checks++; if (fetch_pc !== 32'h600) begin errors++; $display("[TB] FAIL dis_start_pc got %h want 00000600", fetch_pc); end
        cpu_en = 1'b0; jp_addr = 32'h700;
        tick();
        checks++; if (fetch_valid !== 1'b0) begin errors++; $display("[TB] FAIL dis_valid got %b want 0", fetch_valid); end
        checks++; if (fetch_pc !== 32'h600) begin errors++; $display("[TB] FAIL dis_pc got %h want 00000600", fetch_pc); end
        tick();
        jp_taken = 1'b0;
        checks++; if (fetch_pc !== 32'h600) begin errors++; $display("[TB] FAIL idle_hold_pc got %h want 00000600", fetch_pc); end
        cpu_en = 1'b1;
        tick();
        checks++; if (fetch_valid !== 1'b1) begin errors++; $display("[TB] FAIL reen_valid got %b want 1", fetch_valid); end
        checks++; if (fetch_pc !== 32'h600) begin errors++; $display("[TB] FAIL reen_pc got %h want 00000600", fetch_pc); end
        tick();
        checks++; if (fetch_pc !== 32'h608) begin errors++; $display("[TB] FAIL reen_next_pc got %h want 00000608", fetch_pc); end
    endtask

    task automatic test_reset_mid();
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (fetch_valid !== 1'b0) begin errors++; $display("[TB] FAIL midrst_valid got %b want 0", fetch_valid); end
        checks++; if (fetch_pc !== 32'h1000) begin errors++; $display("[TB] FAIL midrst_pc got %h want 00001000", fetch_pc); end
        tick();
        rst_n = 1'b1;
        checks++; if (fetch_valid !== 1'b0) begin errors++; $display("[TB] FAIL postrst_valid got %b want 0", fetch_valid); end
        tick();
        checks++; if (fetch_valid !== 1'b1) begin errors++; $display("[TB] FAIL rerun_valid got %b want 1", fetch_valid); end
        checks++; if (fetch_pc !== 32'h1000) begin errors++; $display("[TB] FAIL rerun_pc got %h want 00001000", fetch_pc); end
        tick();
        checks++; if (fetch_pc !== 32'h1008) begin errors++; $display("[TB] FAIL rerun_next_pc got %h want 00001008", fetch_pc); end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_ready_stall();
        test_jump();
        test_priority();
        test_wrap();
        test_ras();
        test_disable();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
